aes_host_ctrl: RTL and testbench

Byte-stream command controller sitting directly upstream of the 128-bit AES encryption core. It assembles 16-byte keys and plaintexts from a host byte link, drives the core's key/data load handshake, and captures the ciphertext on the core's done pulse. It streams the ciphertext back byte-serially and raises a scope trigger that spans the encryption window for side-channel capture.

---
 rtl/aes_host_ctrl.sv | 178 +++++++++++++++++
 tb/tb_aes_host_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_host_ctrl.sv
// aes_host_ctrl: byte-stream command front end for a 128-bit AES core.
// Assembles key/plaintext from the host link, drives the core's load
// strobes, returns the ciphertext byte-serially and frames a scope trigger
// around the encryption window.
module aes_host_ctrl #(
   parameter int         TIMEOUT  = 64,
   parameter logic [7:0] ACK_BYTE = 8'hA5
) (
   input  logic         CLK,
   input  logic         RSTn,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic         rx_ready,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic [127:0] aes_kin,
   output logic [127:0] aes_din,
   output logic         aes_krdy,
   output logic         aes_drdy,
   output logic         aes_en,
   input  logic [127:0] aes_dout,
   input  logic         aes_kvld,
   input  logic         aes_dvld,
   input  logic         aes_bsy,
   output logic         trig
);

   localparam int             TW   = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RX_KEY,
      S_KLOAD,
      S_KWAIT,
      S_TX_ACK,
      S_RX_PT,
      S_BWAIT,
      S_START,
      S_EWAIT,
      S_TX_CT,
      S_TX_ERR,
      S_TX_NAK
   } state_e;

   state_e         state_q, state_d;
   logic [3:0]     byte_cnt_q, byte_cnt_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [127:0]   key_q, key_d;
   logic [127:0]   pt_q, pt_d;
   logic [127:0]   ct_q, ct_d;

   // The core is held disabled exactly while the controller is in reset.
   assign aes_en  = RSTn;
   assign aes_kin = key_q;
   assign aes_din = pt_q;

   // State, counters and payload registers; reset discards any partial payload.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= '0;
         tmo_q      <= '0;
         key_q      <= '0;
         pt_q       <= '0;
         ct_q       <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         tmo_q      <= tmo_d;
         key_q      <= key_d;
         pt_q       <= pt_d;
         ct_q       <= ct_d;
      end
   end

   // Next-state, datapath updates and Moore-style handshake outputs.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      tmo_d      = '0;
      key_d      = key_q;
      pt_d       = pt_q;
      ct_d       = ct_q;
      rx_ready   = 1'b0;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      aes_krdy   = 1'b0;
      aes_drdy   = 1'b0;
      trig       = 1'b0;

      case (state_q)
         S_IDLE: begin
            rx_ready   = 1'b1;
            byte_cnt_d = '0;
            if (rx_valid) begin
               case (rx_data)
                  8'h01:   state_d = S_RX_KEY;
                  8'h02:   state_d = S_RX_PT;
                  default: state_d = S_TX_NAK;
               endcase
            end
         end
         S_RX_KEY: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               // First byte ends up in [127:120] after 16 left shifts.
               key_d      = {key_q[119:0], rx_data};
               byte_cnt_d = byte_cnt_q + 4'd1;
               if (byte_cnt_q == 4'd15) state_d = S_KLOAD;
            end
         end
         S_KLOAD: begin
            aes_krdy = 1'b1;
            state_d  = S_KWAIT;
         end
         S_KWAIT: begin
            if (aes_kvld) state_d = S_TX_ACK;
         end
         S_TX_ACK: begin
            tx_valid = 1'b1;
            tx_data  = ACK_BYTE;
            if (tx_ready) state_d = S_IDLE;
         end
         S_RX_PT: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               pt_d       = {pt_q[119:0], rx_data};
               byte_cnt_d = byte_cnt_q + 4'd1;
               if (byte_cnt_q == 4'd15) state_d = S_BWAIT;
            end
         end
         S_BWAIT: begin
            if (!aes_bsy) state_d = S_START;
         end
         S_START: begin
            aes_drdy = 1'b1;
            trig     = 1'b1;
            // Timeout count includes the strobe cycle, so it equals the
            // number of cycles elapsed since aes_drdy.
            tmo_d    = TW'(1);
            state_d  = S_EWAIT;
         end
         S_EWAIT: begin
            trig  = 1'b1;
            tmo_d = (tmo_q == TMAX) ? tmo_q : tmo_q + TW'(1);
            if (aes_dvld) begin
               ct_d    = aes_dout;
               state_d = S_TX_CT;
            end else if (tmo_d == TMAX) begin
               state_d = S_TX_ERR;
            end
         end
         S_TX_CT: begin
            tx_valid = 1'b1;
            // Byte 0 is [127:120]; offset is 8*(15-cnt).
            tx_data  = ct_q[{~byte_cnt_q, 3'b000} +: 8];
            if (tx_ready) begin
               byte_cnt_d = byte_cnt_q + 4'd1;
               if (byte_cnt_q == 4'd15) state_d = S_IDLE;
            end
         end
         S_TX_ERR: begin
            tx_valid = 1'b1;
            tx_data  = 8'hFE;
            if (tx_ready) state_d = S_IDLE;
         end
         S_TX_NAK: begin
            tx_valid = 1'b1;
            tx_data  = 8'hFF;
            if (tx_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_aes_host_ctrl.sv
// Directed bench for aes_host_ctrl with a behavioural AES core stand-in
// that knows two reference vectors.
module tb_aes_host_ctrl;

   localparam int TIMEOUT = 64;

   localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] P1 = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] C1 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
   localparam logic [127:0] C0 = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;

   logic         CLK = 1'b0;
   logic         RSTn;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         rx_ready;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic [127:0] aes_kin;
   logic [127:0] aes_din;
   logic         aes_krdy;
   logic         aes_drdy;
   logic         aes_en;
   logic [127:0] aes_dout = '0;
   logic         aes_kvld = 1'b0;
   logic         aes_dvld = 1'b0;
   logic         aes_bsy;
   logic         trig;

   always #5 CLK = ~CLK;

   aes_host_ctrl #(.TIMEOUT(TIMEOUT), .ACK_BYTE(8'hA5)) dut (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .aes_kin  (aes_kin),
      .aes_din  (aes_din),
      .aes_krdy (aes_krdy),
      .aes_drdy (aes_drdy),
      .aes_en   (aes_en),
      .aes_dout (aes_dout),
      .aes_kvld (aes_kvld),
      .aes_dvld (aes_dvld),
      .aes_bsy  (aes_bsy),
      .trig     (trig)
   );

   // Core stand-in: kvld one cycle after krdy, dvld 11 cycles after drdy.
   logic [3:0] m_cnt     = '0;
   logic       m_busy    = 1'b0;
   bit         no_dvld   = 1'b0;
   bit         force_bsy = 1'b0;

   assign aes_bsy = m_busy | force_bsy;

   function automatic logic [127:0] model_ct(input logic [127:0] k, input logic [127:0] d);
      if (k == K1 && d == P1) return C1;
      if (k == '0 && d == '0) return C0;
      return k ^ d ^ 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
   endfunction

   always @(posedge CLK) begin
      aes_kvld <= aes_krdy;
      aes_dvld <= (m_cnt == 4'd1) && !aes_drdy && !no_dvld;
      if (aes_drdy) begin
         m_cnt    <= 4'd10;
         m_busy   <= 1'b1;
         aes_dout <= model_ct(aes_kin, aes_din);
      end else begin
         if (m_cnt != 0) m_cnt <= m_cnt - 4'd1;
         m_busy <= (m_cnt != 0);
      end
   end

   // Event counters.
   int krdy_n = 0, drdy_n = 0, trig_n = 0, txv_n = 0;
   always @(posedge CLK) begin
      if (aes_krdy) krdy_n <= krdy_n + 1;
      if (aes_drdy) drdy_n <= drdy_n + 1;
      if (trig)     trig_n <= trig_n + 1;
      if (tx_valid) txv_n  <= txv_n + 1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      bit ok;
      if (gap) repeat ($urandom_range(0, 3)) @(negedge CLK);
      @(negedge CLK);
      rx_data  = b;
      rx_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (rx_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      if (!ok) check_val("rx_ready_wait", 128'(0), 128'(1));
      @(posedge CLK);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] cmd, input logic [127:0] payload, input bit gap);
      send_byte(cmd, gap);
      for (int i = 0; i < 16; i++) send_byte(payload[127-8*i -: 8], gap);
   endtask

   task automatic recv_bytes(input int n, input bit rnd, output logic [127:0] val);
      bit         got;
      bit         held;
      logic [7:0] hold_d;
      val = '0;
      for (int k = 0; k < n; k++) begin
         got    = 1'b0;
         held   = 1'b0;
         hold_d = '0;
         for (int w = 0; w < 300 && !got; w++) begin
            @(negedge CLK);
            if (held) check_val("tx_hold", 128'({tx_valid, tx_data}), 128'({1'b1, hold_d}));
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && tx_ready) begin
               val = {val[119:0], tx_data};
               got = 1'b1;
               @(posedge CLK);
               #1 tx_ready = 1'b0;
            end else begin
               held   = tx_valid;
               hold_d = tx_data;
            end
         end
         if (!got) check_val("tx_wait", 128'(0), 128'(1));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_ctrl"}, 128'({rx_ready, tx_valid, aes_krdy, aes_drdy, trig, aes_en}),
                128'(6'b100000));
      check_val({tag, "_txd"}, 128'(tx_data), 128'(0));
      check_val({tag, "_kin"}, aes_kin, 128'(0));
      check_val({tag, "_din"}, aes_din, 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      logic [127:0] v;
      int           s0, s1;
      bit           found;

      RSTn     = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge CLK);
      check_reset_outputs("rst");
      RSTn = 1'b1;
      @(negedge CLK);
      check_val("en_after_rst", 128'(aes_en), 128'(1));

      // Key load with ACK
      s0 = krdy_n;
      send_cmd(8'h01, K1, 1'b0);
      @(negedge CLK);
      check_val("krdy_pulse", 128'(aes_krdy), 128'(1));
      check_val("kin", aes_kin, K1);
      @(negedge CLK);
      check_val("kwait", 128'({aes_krdy, tx_valid}), 128'(2'b00));
      @(negedge CLK);
      check_val("ack_byte", 128'({tx_valid, tx_data}), 128'({1'b1, 8'hA5}));
      tx_ready = 1'b1;
      @(posedge CLK);
      #1 tx_ready = 1'b0;
      check_val("krdy_count", 128'(krdy_n - s0), 128'(1));
      @(negedge CLK);
      check_val("idle_after_ack", 128'({rx_ready, tx_valid}), 128'(2'b10));

      // Encrypt with idle core, cycle-exact timing
      s0 = trig_n;
      s1 = drdy_n;
      send_cmd(8'h02, P1, 1'b0);
      @(negedge CLK);
      check_val("bwait", 128'({aes_drdy, trig}), 128'(2'b00));
      @(negedge CLK);
      check_val("start", 128'({aes_drdy, trig}), 128'(2'b11));
      check_val("din", aes_din, P1);
      repeat (11) @(negedge CLK);
      check_val("dvld_cycle", 128'({trig, tx_valid, aes_dvld}), 128'(3'b101));
      @(negedge CLK);
      check_val("first_ct", 128'({trig, tx_valid, rx_ready, tx_data}), 128'({3'b010, 8'h69}));
      recv_bytes(16, 1'b0, v);
      check_val("ct_bytes", v, C1);
      check_val("trig_cycles", 128'(trig_n - s0), 128'(12));
      check_val("drdy_count", 128'(drdy_n - s1), 128'(1));
      @(negedge CLK);
      check_val("b2b_ready", 128'({rx_ready, tx_valid}), 128'(2'b10));

      // Encrypt again with gapped rx and random tx_ready
      send_cmd(8'h02, P1, 1'b1);
      recv_bytes(16, 1'b1, v);
      check_val("ct_random", v, C1);
      check_val("kin_stable", aes_kin, K1);

      // Unknown command, then encrypt behind a busy core
      send_byte(8'h7E, 1'b0);
      recv_bytes(1, 1'b0, v);
      check_val("nak_byte", 128'(v[7:0]), 128'(8'hFF));
      force_bsy = 1'b1;
      s1 = drdy_n;
      send_cmd(8'h02, P1, 1'b0);
      repeat (5) @(negedge CLK);
      check_val("bsy_hold", 128'({aes_drdy, 8'(drdy_n - s1)}), 128'(0));
      force_bsy = 1'b0;
      recv_bytes(16, 1'b0, v);
      check_val("ct_after_nak", v, C1);

      // Timeout: core never returns dvld
      no_dvld = 1'b1;
      send_cmd(8'h02, P1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge CLK);
         if (aes_drdy) found = 1'b1;
      end
      check_val("tmo_drdy_seen", 128'(found), 128'(1));
      repeat (TIMEOUT - 1) @(negedge CLK);
      check_val("tmo_before", 128'({trig, tx_valid}), 128'(2'b10));
      @(negedge CLK);
      check_val("tmo_err", 128'({trig, tx_valid, tx_data}), 128'({2'b01, 8'hFE}));
      recv_bytes(1, 1'b0, v);
      check_val("tmo_byte", 128'(v[7:0]), 128'(8'hFE));
      @(negedge CLK);
      check_val("tmo_trig_low", 128'(trig), 128'(0));
      no_dvld = 1'b0;
      repeat (15) @(negedge CLK);

      // Reset mid-payload, then encrypt with the cleared key
      send_byte(8'h02, 1'b0);
      for (int i = 0; i < 8; i++) send_byte(8'hAA, 1'b0);
      @(negedge CLK);
      RSTn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;
      s0 = txv_n;
      repeat (5) @(negedge CLK);
      check_val("no_tx_after_rst", 128'({tx_valid, 8'(txv_n - s0)}), 128'(0));
      send_cmd(8'h02, 128'(0), 1'b0);
      recv_bytes(16, 1'b0, v);
      check_val("ct_zero_key", v, C0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
